alu_arbiter: RTL
================

Name: alu_arbiter

Overview:
- Shares the single 32-bit ALU between two requesters through valid/ready handshakes.
  - Requester 0: execute stage.
  - Requester 1: secondary client, e.g. address-gen or multicycle sequencer.
- Per cycle: arbitrates, drives the winner's op and operands into one alu instance, and registers the result into a one-entry response buffer tagged with the owner.
- The buffered result returns on that owner's response channel.

Parameters:
- STARVE_LIMIT, default 4: maximum consecutive requester-0 grants while requester 1 waits. Used only when ALU_ARB_FIXED_PRIO_EN is defined. Legal range 1..15.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- req_valid  in  [2]x1  request valid, one per requester
- req_ready  out  [2]x1  request accepted this cycle (handshake = valid & ready)
- req_aluop  in  [2]x alu_ops  operation per requester
- req_a  in  [2]x32  operand a
- req_b  in  [2]x32  operand b
- resp_valid  out  [2]x1  result valid for requester i
- resp_ready  in  [2]x1  requester i consumes result
- resp_f  out  32  result, shared; meaningful for the requester whose resp_valid is high

Behaviour:
- Buffer FSM, type arb_state_t:
  - EMPTY: no result held.
  - FULL: result held, with owner tag and f register.
- slot_free = (state==EMPTY) | (state==FULL & resp_ready[owner] & resp_valid[owner]).
- Arbitration, combinational from req_valid and rr_ptr:
  - grant[i] = winner among valid requesters; at most one grant per cycle.
  - req_ready[i] = grant[i] & slot_free.
  - req_ready must not depend combinationally on req_aluop, req_a or req_b.
- Round-robin (default build):
  - rr_ptr names the preferred requester.
  - Only one valid requester: it wins.
  - Both valid: rr_ptr wins.
  - After any accepted handshake, rr_ptr <= ~winner.
  - rr_ptr does not change when no handshake occurs.
- Accept:
  - On a handshake at edge N: f <= alu(req_aluop, req_a, req_b) of the winner, owner <= winner, state <= FULL.
  - resp_valid[owner] is high from cycle N+1. Latency is 1 cycle.
- Drain:
  - FULL with resp_ready[owner]=1 and no new handshake: state <= EMPTY.
  - Drain and accept in the same cycle: state stays FULL with the new owner and f. Full throughput is 1 op/cycle.
- Backpressure:
  - FULL with resp_ready[owner]=0: f, owner and resp_valid hold stable.
  - Both req_ready stay 0.
  - resp_ready of the non-owner is ignored.
- Requester rule: once req_valid is high it must hold, with payload stable, until req_ready. Violations are a bench assertion error, not handled by RTL.
- ALU semantics are unchanged:
  - Shift amounts use b[4:0].
  - sra is arithmetic.
  - add and sub wrap modulo 2^32.
- resp_valid[1-owner] is always 0. Both resp_valid high at once is illegal (assert).
- Reset, synchronous, from the edge where rst=1:
  - state=EMPTY, resp_valid=0, req_ready=0, resp_f=0, owner=0, rr_ptr=0, starve_cnt=0.
  - A result pending mid-operation is dropped with no response.
  - A handshake coincident with rst is discarded.

Optional Feature:
- Macro: ALU_ARB_FIXED_PRIO_EN.
- Defined: fixed priority to requester 0, with starvation guard.
  - 4-bit starve_cnt increments on each requester-0 grant while req_valid[1]=1.
  - starve_cnt clears on any requester-1 grant, or when req_valid[1]=0.
  - When starve_cnt==STARVE_LIMIT, requester 1 wins the next arbitration.
  - rr_ptr is unused.
- Undefined: round-robin as above; starve_cnt and STARVE_LIMIT logic are absent.

Decomposition:
- rv32i_types (shared package) gains:
  - typedef enum {ARB_EMPTY, ARB_FULL} arb_state_t
  - localparam ALU_ARB_NREQ = 2
  - alu_ops is reused unchanged.
- Sub-modules:
  - alu_arb_select: combinational winner select from req_valid, rr_ptr and starve state; outputs grant[2].
  - The existing alu module is instantiated once, with its input selected by the winner.
- The top level holds the FSM, buffer and pointer registers.

Test Plan:
- Single request: req0 alu_add, a=5, b=7; resp_ready=1 -> resp_valid[0] one cycle after the handshake with resp_f=12; resp_valid[1]=0 throughout.
- Simultaneous after reset: req0 alu_sub 10,3 and req1 alu_sll 1,4 -> req0 served first with resp_f=7 on port 0, then req1 served the next cycle with resp_f=16 on port 1; one result per cycle.
- Backpressure: result 0xC0000000 held (alu_sra a=0x80000000, b=0x21, effective shift 1) with resp_ready[0]=0 for 3 cycles -> resp_f stable, both req_ready=0. When resp_ready rises, drain and accept of a waiting req1 happen in the same cycle.
- Saturation: both requesters continuously valid for 8 handshakes, resp_ready=1 -> grant order 0,1,0,1,0,1,0,1; 4 results per port; no idle cycles.
- Reset mid-op: assert rst while FULL (owner=1) -> next cycle resp_valid=0 and req_ready=0. After rst falls, simultaneous requests grant requester 0 first (rr_ptr=0).
- With ALU_ARB_FIXED_PRIO_EN and STARVE_LIMIT=4, both continuously valid -> grant pattern 0,0,0,0,1,0,0,0,0,1.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// Shared types for the two-requester ALU arbiter: ALU op encoding, response
// buffer state and requester count.
package alu_arbiter_pkg;

    typedef enum logic [2:0] {
        alu_add = 3'b000,
        alu_sll = 3'b001,
        alu_sra = 3'b010,
        alu_sub = 3'b011,
        alu_xor = 3'b100,
        alu_srl = 3'b101,
        alu_or  = 3'b110,
        alu_and = 3'b111
    } alu_ops;

    typedef enum logic {
        ARB_EMPTY = 1'b0,
        ARB_FULL  = 1'b1
    } arb_state_t;

    localparam int ALU_ARB_NREQ = 2;

    function automatic logic [ALU_ARB_NREQ-1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between the two ALU requesters and the arbiter.
interface alu_arbiter_if;
    import alu_arbiter_pkg::*;

    logic [ALU_ARB_NREQ-1:0] req_valid;
    logic [ALU_ARB_NREQ-1:0] req_ready;
    alu_ops                  req_aluop [ALU_ARB_NREQ];
    logic [31:0]             req_a     [ALU_ARB_NREQ];
    logic [31:0]             req_b     [ALU_ARB_NREQ];
    logic [ALU_ARB_NREQ-1:0] resp_valid;
    logic [ALU_ARB_NREQ-1:0] resp_ready;
    logic [31:0]             resp_f;

    modport master (
        output req_valid, req_aluop, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_f
    );

    modport slave (
        input  req_valid, req_aluop, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_f
    );

endinterface

// File: rtl/alu_arbiter_alu.sv
// Shared 32-bit ALU: shifts use b[4:0], sra is arithmetic, add/sub wrap.
module alu
    import alu_arbiter_pkg::*;
(
    input  alu_ops      aluop,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] f
);

    // Operation decode
    always_comb begin
        f = 32'h0000_0000;
        case (aluop)
            alu_add: f = a + b;
            alu_sll: f = a << b[4:0];
            alu_sra: f = $unsigned($signed(a) >>> b[4:0]);
            alu_sub: f = a - b;
            alu_xor: f = a ^ b;
            alu_srl: f = a >> b[4:0];
            alu_or:  f = a | b;
            alu_and: f = a & b;
            default: f = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/alu_arbiter_select.sv
// Winner select between the two requesters; `prefer` breaks ties when both
// are valid (round-robin pointer or starvation override, chosen by the top).
module alu_arb_select
    import alu_arbiter_pkg::*;
(
    input  logic [ALU_ARB_NREQ-1:0] req_valid,
    input  logic                    prefer,
    output logic [ALU_ARB_NREQ-1:0] grant,
    output logic                    winner
);

    // Pick one winner among valid requesters
    always_comb begin
        winner = 1'b0;
        grant  = 2'b00;
        case (req_valid)
            2'b01:   winner = 1'b0;
            2'b10:   winner = 1'b1;
            2'b11:   winner = prefer;
            default: winner = 1'b0;
        endcase
        if (req_valid != 2'b00) begin
            grant = onehot2(winner);
        end else begin
            grant = 2'b00;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester ALU arbiter with a one-entry tagged response buffer.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority to requester 0 with a starvation guard.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    alu_arbiter_if.slave  bus
);

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
        $error("STARVE_LIMIT must be within 1..15");
    end

    arb_state_t              state_r;
    logic                    owner_r;
    logic [31:0]             f_r;
    logic [ALU_ARB_NREQ-1:0] resp_valid_r;
    logic [ALU_ARB_NREQ-1:0] grant_s;
    logic                    winner_s;
    logic                    prefer_s;
    logic                    drain_s;
    logic                    slot_free_s;
    logic                    hs_s;
    logic [31:0]             alu_f_s;

`ifdef ALU_ARB_FIXED_PRIO_EN
    logic [3:0] starve_cnt_r;
    assign prefer_s = (starve_cnt_r == 4'(STARVE_LIMIT));
`else
    logic rr_ptr_r;
    assign prefer_s = rr_ptr_r;
`endif

    alu_arb_select u_select (
        .req_valid (bus.req_valid),
        .prefer    (prefer_s),
        .grant     (grant_s),
        .winner    (winner_s)
    );

    alu u_alu (
        .aluop (bus.req_aluop[winner_s]),
        .a     (bus.req_a[winner_s]),
        .b     (bus.req_b[winner_s]),
        .f     (alu_f_s)
    );

    // The non-owner's resp_ready never matters: only the owner can drain.
    assign drain_s     = resp_valid_r[owner_r] & bus.resp_ready[owner_r];
    assign slot_free_s = (state_r == ARB_EMPTY) | ((state_r == ARB_FULL) & drain_s);
    assign hs_s        = |(bus.req_valid & bus.req_ready);

    // Handshake acceptance, suppressed while in reset
    always_comb begin
        if (rst || !slot_free_s) begin
            bus.req_ready = 2'b00;
        end else begin
            bus.req_ready = grant_s;
        end
    end

    assign bus.resp_valid = resp_valid_r;
    assign bus.resp_f     = f_r;

    // Response buffer FSM: accept, drain, or both in one cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ARB_EMPTY;
            owner_r      <= 1'b0;
            f_r          <= 32'h0000_0000;
            resp_valid_r <= 2'b00;
        end else begin
            case (state_r)
                ARB_EMPTY, ARB_FULL: begin
                    if (hs_s) begin
                        state_r      <= ARB_FULL;
                        owner_r      <= winner_s;
                        f_r          <= alu_f_s;
                        resp_valid_r <= onehot2(winner_s);
                    end else if (drain_s) begin
                        state_r      <= ARB_EMPTY;
                        resp_valid_r <= 2'b00;
                    end else begin
                        state_r      <= state_r;
                    end
                end
                default: begin
                    state_r      <= ARB_EMPTY;
                    resp_valid_r <= 2'b00;
                end
            endcase
        end
    end

`ifdef ALU_ARB_FIXED_PRIO_EN
    // Count back-to-back requester-0 wins while requester 1 is kept waiting
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_r <= 4'd0;
        end else if (!bus.req_valid[1]) begin
            starve_cnt_r <= 4'd0;
        end else if (hs_s && winner_s) begin
            starve_cnt_r <= 4'd0;
        end else if (hs_s) begin
            starve_cnt_r <= starve_cnt_r + 4'd1;
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end
`else
    // Round-robin pointer moves only on an accepted handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_r <= 1'b0;
        end else if (hs_s) begin
            rr_ptr_r <= ~winner_s;
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end
`endif

endmodule
